uart_receiver: RTL and testbench

//   Serial UART receiver, 16x oversampled, LSB-first, 1 start / DBITS data / 1 stop, no parity.

---
 rtl/uart_receiver.sv | 111 +++++++++++
 tb/tb_uart_receiver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: 1 start bit, DBITS data bits LSB first, 1 stop bit, no parity.
// Each bit is sampled at its mid-point; a completed word is announced by a one-cycle rx_done strobe.
module uart_receiver #(
    parameter int unsigned DBITS   = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    output logic [DBITS-1:0] data_out,
    output logic             rx_done,
    output logic             frame_err
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic             rx_meta, rx_s;
    logic [4:0]       tick, tick_nx;
    logic [3:0]       nbits, nbits_nx;
    logic [DBITS-1:0] shift, shift_nx;
    logic             done_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            tick      <= '0;
            nbits     <= '0;
            shift     <= '0;
            data_out  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_nx;
            tick    <= tick_nx;
            nbits   <= nbits_nx;
            shift   <= shift_nx;
            rx_done <= done_nx;
            // Output word and error flag are only updated on the completing stop tick.
            if (done_nx) begin
                data_out  <= shift;
                frame_err <= ~rx_s;
            end
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        nbits_nx = nbits;
        shift_nx = shift;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    tick_nx  = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tick == 5'd7) begin
                        if (!rx_s) begin
                            state_nx = DATA;
                            tick_nx  = '0;
                            nbits_nx = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tick_nx = tick + 5'd1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tick == 5'd15) begin
                        tick_nx = '0;
                        // Shift-then-insert keeps the DBITS==1 case legal.
                        shift_nx            = shift >> 1;
                        shift_nx[DBITS-1]   = rx_s;
                        if (nbits == 4'(DBITS - 1)) begin
                            state_nx = STOP;
                        end else begin
                            nbits_nx = nbits + 4'd1;
                        end
                    end else begin
                        tick_nx = tick + 5'd1;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (tick == 5'(SB_TICK - 1)) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        tick_nx = tick + 5'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8-bit/16-tick instance and a 7-bit/32-tick-stop instance,
// with expected words queued as frames are driven and checked when rx_done fires.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx7 = 1'b1;
    logic       sample_tick = 1'b0;
    logic [7:0] data_out;
    logic       rx_done, frame_err;
    logic [6:0] data_out7;
    logic       rx_done7, frame_err7;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done7_cnt = 0;
    logic done_prev = 1'b0;
    logic done7_prev = 1'b0;
    logic [8:0] exp_q[$];
    logic [7:0] exp7_q[$];
    int unsigned tdiv = 0;

    uart_receiver #(.DBITS(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .sample_tick(sample_tick),
        .data_out(data_out), .rx_done(rx_done), .frame_err(frame_err)
    );

    uart_receiver #(.DBITS(7), .SB_TICK(32)) dut7 (
        .clk(clk), .reset(reset), .rx(rx7), .sample_tick(sample_tick),
        .data_out(data_out7), .rx_done(rx_done7), .frame_err(frame_err7)
    );

    always #5 clk = ~clk;

    // One sample_tick every 4 clocks, changed on the falling edge.
    always @(negedge clk) begin
        sample_tick = (tdiv == 2);
        tdiv = (tdiv == 3) ? 0 : tdiv + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (rx_done) begin
            done_cnt++;
            chk("done_width", {31'd0, done_prev}, 32'd0);
            chk("unexpected_done", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
                chk("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
            end
        end
        done_prev = rx_done;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_done7) begin
            done7_cnt++;
            chk("done7_width", {31'd0, done7_prev}, 32'd0);
            chk("unexpected_done7", {31'd0, exp7_q.size() != 0}, 32'd1);
            if (exp7_q.size() != 0) begin
                e = exp7_q.pop_front();
                chk("data_out7", {25'd0, data_out7}, {25'd0, e[6:0]});
                chk("frame_err7", {31'd0, frame_err7}, {31'd0, e[7]});
            end
        end
        done7_prev = rx_done7;
    end

    // Holds a line level for n sample ticks (4 clocks each).
    task automatic drive_bit(input logic lvl, input int n, input bit sel);
        if (sel) rx7 = lvl; else rx = lvl;
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int nb, input logic stop, input int stop_n, input bit sel);
        drive_bit(1'b0, 16, sel);
        for (int i = 0; i < nb; i++) drive_bit(d[i], 16, sel);
        drive_bit(stop, stop_n, sel);
        if (sel) rx7 = 1'b1; else rx = 1'b1;
    endtask

    initial begin
        logic [7:0] d81;
        d81 = 8'h81;

        rx = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_rx_done", {31'd0, rx_done}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_data_out7", {25'd0, data_out7}, 32'd0);
        reset = 1'b0;
        rx = 1'b1;
        drive_bit(1'b1, 32, 0);
        chk("rst_no_frame", done_cnt, 0);

        exp_q.push_back({1'b0, 8'hA5});
        send(8'hA5, 8, 1'b1, 16, 0);
        drive_bit(1'b1, 16, 0);
        chk("a5_count", done_cnt, 1);
        chk("a5_hold", {24'd0, data_out}, 32'hA5);

        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        send(8'h00, 8, 1'b1, 16, 0);
        send(8'hFF, 8, 1'b1, 16, 0);
        drive_bit(1'b1, 16, 0);
        chk("b2b_count", done_cnt, 3);

        drive_bit(1'b0, 4, 0);
        drive_bit(1'b1, 32, 0);
        chk("glitch_no_done", done_cnt, 3);
        exp_q.push_back({1'b0, 8'h3C});
        send(8'h3C, 8, 1'b1, 16, 0);
        drive_bit(1'b1, 16, 0);
        chk("3c_count", done_cnt, 4);

        // Stop held low long enough to be sampled, released before the re-armed start is judged.
        exp_q.push_back({1'b1, 8'h55});
        send(8'h55, 8, 1'b0, 12, 0);
        drive_bit(1'b1, 32, 0);
        chk("break_count", done_cnt, 5);
        chk("break_err_hold", {31'd0, frame_err}, 32'd1);

        drive_bit(1'b0, 16, 0);
        for (int i = 0; i < 4; i++) drive_bit(d81[i], 16, 0);
        drive_bit(d81[4], 8, 0);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive_bit(1'b1, 16, 0);
        chk("midrst_no_done", done_cnt, 5);
        chk("midrst_data_out", {24'd0, data_out}, 32'd0);
        exp_q.push_back({1'b0, 8'h7E});
        send(8'h7E, 8, 1'b1, 16, 0);
        drive_bit(1'b1, 16, 0);
        chk("7e_count", done_cnt, 6);

        exp7_q.push_back({1'b0, 7'h2A});
        send(8'h2A, 7, 1'b1, 32, 1);
        drive_bit(1'b1, 16, 1);
        chk("d7_count", done7_cnt, 1);
        chk("d7_hold", {25'd0, data_out7}, 32'h2A);

        chk("queue_empty", exp_q.size(), 0);
        chk("queue7_empty", exp7_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
